// File: rtl/mystic_pkg.sv
// Shared constants for the mystic RV64 core: data width, register address
// width and the fixed writeback requester indices.
package mystic_pkg;

   localparam int XLEN            = 64;
   localparam int REG_ADDR_W      = 5;
   localparam int REQ_ALU         = 0;
   localparam int REQ_LSU         = 1;
   localparam int REQ_MDU         = 2;
   localparam int NUM_REQ_DEFAULT = 3;

endpackage

// File: rtl/mystic_rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// above ptr_i, wrapping past NUM_REQ-1 back to 0. Shared with other port arbiters.
module mystic_rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               gnt_valid_o
);

   always_comb begin
      int slot;
      gnt_o       = '0;
      idx_o       = '0;
      gnt_valid_o = 1'b0;
      slot        = 0;
      // Walk the priority order ptr, ptr+1, ... and take the first hit.
      for (int i = 0; i < NUM_REQ; i++) begin
         slot = (int'(ptr_i) + i) % NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (en_i && !gnt_valid_o && (j == slot) && req_i[j]) begin
               gnt_o[j]    = 1'b1;
               idx_o       = IDX_W'(j);
               gnt_valid_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mystic_wb_arbiter.sv
// Register-file write-port arbiter: one round-robin grant per cycle from the
// writeback sources, registered write triple, saturating contention counter.
module mystic_wb_arbiter
   import mystic_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT,
   parameter int XLEN    = mystic_pkg::XLEN,
   parameter int CNT_W   = 16
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd_i,
   input  logic [NUM_REQ*XLEN-1:0]      req_data_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   input  logic                         stall_i,
   output logic                         regfile_WriteEnable_o,
   output logic [REG_ADDR_W-1:0]        instr_rd_o,
   output logic [XLEN-1:0]              regfile_WriteData_o,
   output logic [CNT_W-1:0]             contention_cnt_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    gnt;
   logic [IDX_W-1:0]      gnt_idx;
   logic                  gnt_vld;
   logic [IDX_W-1:0]      ptr_d, ptr_q;
   logic                  we_d, we_q;
   logic [REG_ADDR_W-1:0] rd_d, rd_q, rd_sel;
   logic [XLEN-1:0]       data_d, data_q, data_sel;
   logic [CNT_W-1:0]      cnt_d, cnt_q;
   logic                  seen, multi;

   // Reset gates the grant so nothing is consumed while the core is held.
   mystic_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_i       (req_valid_i),
      .ptr_i       (ptr_q),
      .en_i        (rstn_i & ~stall_i),
      .gnt_o       (gnt),
      .idx_o       (gnt_idx),
      .gnt_valid_o (gnt_vld)
   );

   assign req_ready_o = gnt;

   always_comb begin
      rd_sel   = '0;
      data_sel = '0;
      seen     = 1'b0;
      multi    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt[k]) begin
            rd_sel   = req_rd_i[REG_ADDR_W*k +: REG_ADDR_W];
            data_sel = req_data_i[XLEN*k +: XLEN];
         end
         if (req_valid_i[k]) begin
            multi = multi | seen;
            seen  = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d  = ptr_q;
      we_d   = 1'b0;
      rd_d   = rd_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      if (gnt_vld) begin
         ptr_d  = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
         we_d   = (rd_sel != '0);
         rd_d   = rd_sel;
         data_d = data_sel;
      end
      if (!stall_i && multi && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         ptr_q  <= '0;
         we_q   <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         ptr_q  <= ptr_d;
         we_q   <= we_d;
         rd_q   <= rd_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign regfile_WriteEnable_o = we_q;
   assign instr_rd_o            = rd_q;
   assign regfile_WriteData_o   = data_q;
   assign contention_cnt_o      = cnt_q;

endmodule

// File: tb/tb_mystic_wb_arbiter.sv
// Bench for mystic_wb_arbiter: a per-cycle behavioural model checked on every
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_mystic_wb_arbiter;

   localparam int N     = 3;
   localparam int XL    = 64;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rstn;
   logic [N-1:0]    valid;
   logic [4:0]      rd   [N];
   logic [XL-1:0]   data [N];
   logic            stall;
   logic [N*5-1:0]  req_rd;
   logic [N*XL-1:0] req_data;
   logic [N-1:0]    ready;
   logic            we;
   logic [4:0]      wrd;
   logic [XL-1:0]   wdata;
   logic [CW-1:0]   cnt;

   int vectors     = 0;
   int miscompares = 0;
   bit checking    = 1'b0;

   // behavioural model state
   int            m_ptr;
   bit            m_we;
   logic [4:0]    m_rd;
   logic [XL-1:0] m_data;
   int            m_cnt;

   logic [N-1:0]  glog [9];

   assign req_rd   = {rd[2], rd[1], rd[0]};
   assign req_data = {data[2], data[1], data[0]};

   always #5 clk = ~clk;

   mystic_wb_arbiter #(.NUM_REQ(N), .XLEN(XL), .CNT_W(CW)) dut (
      .clk_i                 (clk),
      .rstn_i                (rstn),
      .req_valid_i           (valid),
      .req_rd_i              (req_rd),
      .req_data_i            (req_data),
      .req_ready_o           (ready),
      .stall_i               (stall),
      .regfile_WriteEnable_o (we),
      .instr_rd_o            (wrd),
      .regfile_WriteData_o   (wdata),
      .contention_cnt_o      (cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner = valid requester with the smallest forward distance from ptr.
   function automatic int model_winner();
      int best = -1;
      int bestd = N;
      if (!rstn || stall) return -1;
      for (int k = 0; k < N; k++) begin
         if (valid[k] && ((k - m_ptr + N) % N) < bestd) begin
            bestd = (k - m_ptr + N) % N;
            best  = k;
         end
      end
      return best;
   endfunction

   always @(posedge clk) begin
      int w;
      w = model_winner();
      if (!rstn) begin
         m_ptr = 0; m_we = 0; m_rd = '0; m_data = '0; m_cnt = 0;
      end else begin
         m_we = 0;
         if (w >= 0) begin
            m_we   = (rd[w] != 5'd0);
            m_rd   = rd[w];
            m_data = data[w];
            m_ptr  = (w + 1) % N;
         end
         if (!stall && $countones(valid) >= 2 && m_cnt < CMAX) m_cnt++;
      end
   end

   always @(negedge clk) begin
      int w;
      logic [N-1:0] exp_rdy;
      if (checking) begin
         w = model_winner();
         exp_rdy = '0;
         if (w >= 0) exp_rdy[w] = 1'b1;
         chk("model_ready", 64'(ready), 64'(exp_rdy));
         chk("model_we",    64'(we),    64'(m_we));
         chk("model_rd",    64'(wrd),   64'(m_rd));
         chk("model_data",  wdata,      m_data);
         chk("model_cnt",   64'(cnt),   64'(m_cnt));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn  = 1'b0;
      stall = 1'b0;
      valid = 3'b111;
      rd[0] = 5'd1; rd[1] = 5'd2; rd[2] = 5'd3;
      data[0] = 64'hA0; data[1] = 64'hA1; data[2] = 64'hA2;

      // reset held three edges with all valids high
      cyc();
      checking = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_ready", 64'(ready), 64'h0);
         chk("rst_we",    64'(we),    64'h0);
         chk("rst_rd",    64'(wrd),   64'h0);
         chk("rst_data",  wdata,      64'h0);
         chk("rst_cnt",   64'(cnt),   64'h0);
         cyc();
      end
      rstn = 1'b1;
      @(negedge clk);
      chk("first_grant", 64'(ready), 64'b001);
      cyc();

      // single ALU write
      valid = 3'b001; rd[0] = 5'd5; data[0] = 64'hDEAD_BEEF_0000_0001;
      @(negedge clk);
      chk("alu_ready", 64'(ready), 64'b001);
      cyc();
      valid = 3'b000;
      @(negedge clk);
      chk("alu_we",   64'(we),  64'h1);
      chk("alu_rd",   64'(wrd), 64'd5);
      chk("alu_data", wdata,    64'hDEAD_BEEF_0000_0001);
      cyc();
      @(negedge clk);
      chk("alu_we_drop", 64'(we), 64'h0);
      chk("alu_hold_rd", 64'(wrd), 64'd5);

      // round-robin from a fresh reset
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      valid = 3'b111; rd[0] = 5'd1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         glog[i] = ready;
         cyc();
      end
      valid = 3'b000;
      @(negedge clk);
      for (int i = 0; i < 9; i++) chk("rr_order", 64'(glog[i]), 64'(1 << (i % 3)));
      chk("rr_cnt", 64'(cnt), 64'd9);
      chk("rr_last_rd", 64'(wrd), 64'd3);

      // x0 destination from LSU
      valid = 3'b010; rd[1] = 5'd0; data[1] = 64'h1234;
      @(negedge clk);
      chk("x0_ready", 64'(ready), 64'b010);
      cyc();
      valid = 3'b111; rd[1] = 5'd2;
      @(negedge clk);
      chk("x0_we",    64'(we),    64'h0);
      chk("x0_rd",    64'(wrd),   64'd0);
      chk("x0_data",  wdata,      64'h1234);
      chk("x0_ptr",   64'(ready), 64'b100);
      cyc();

      // stall with ALU and LSU pending; counter frozen at 10
      valid = 3'b011; stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_ready", 64'(ready), 64'h0);
         chk("stall_cnt",   64'(cnt),   64'd10);
         if (i > 0) chk("stall_we", 64'(we), 64'h0);
         cyc();
      end
      stall = 1'b0;
      @(negedge clk);
      chk("stall_resume", 64'(ready), 64'b001);
      cyc();

      // saturation
      valid = 3'b111;
      repeat (20) cyc();
      valid = 3'b000;
      @(negedge clk);
      chk("sat_cnt", 64'(cnt), 64'd15);
      valid = 3'b011;
      cyc();
      @(negedge clk);
      chk("sat_hold", 64'(cnt), 64'd15);

      // reset mid-operation discards the pending grant
      valid = 3'b111; rstn = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 64'(ready), 64'h0);
      cyc();
      rstn = 1'b1; valid = 3'b000;
      @(negedge clk);
      chk("midrst_we",  64'(we),  64'h0);
      chk("midrst_cnt", 64'(cnt), 64'h0);
      cyc();

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
